// File: rtl/mul_div_seq.sv
// Bit-serial unsigned multiply (shift-add) / divide (restoring) unit.
// One multiplier or quotient bit per clock; WIDTH iterations per operation.
//
//   state  | meaning
//   S_IDLE | waiting for START, results held
//   S_RUN  | one iteration per clock, BUSY high
//   S_DONE | DONE pulse, results valid; START accepted here too
module mul_div_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             MUL_BAR,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic [WIDTH-1:0] RESULT_LO,
    output logic             DIV_BY_ZERO
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic             mode_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] res_hi_q;
    logic [WIDTH-1:0] res_lo_q;
    logic             dbz_q;

    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_s;
    logic             trial_neg;

    // opnd_q holds the multiplicand in multiply mode and the divisor in divide
    // mode. The remainder is always < divisor, so hi_q needs only WIDTH bits;
    // the extra remainder bit exists only transiently in rem_s.
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        rem_s     = {hi_q, lo_q[WIDTH-1]};
        trial_neg = (rem_s < {1'b0, opnd_q});
        if (mode_q) begin
            hi_d = trial_neg ? rem_s[WIDTH-1:0] : (rem_s[WIDTH-1:0] - opnd_q);
            lo_d = {lo_q[WIDTH-2:0], ~trial_neg};
        end else begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        mode_q <= MUL_BAR;
                        opnd_q <= MUL_BAR ? B : A;
                        hi_q   <= '0;
                        lo_q   <= MUL_BAR ? A : B;
                        cnt_q  <= '0;
                        dbz_q  <= 1'b0;
                        if (MUL_BAR && (B == '0)) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            res_hi_q <= A;
                            res_lo_q <= '1;
                            dbz_q    <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        res_hi_q <= hi_d;
                        res_lo_q <= lo_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign RESULT_HI   = res_hi_q;
    assign RESULT_LO   = res_lo_q;
    assign DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq: directed cases, abort/ignore scenarios
// and randomized operations checked against plain-arithmetic expectations.
module tb_mul_div_seq;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic         MUL_BAR;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] RESULT_HI;
    logic [W-1:0] RESULT_LO;
    logic         DIV_BY_ZERO;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    mul_div_seq #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .MUL_BAR    (MUL_BAR),
        .A          (A),
        .B          (B),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .RESULT_HI  (RESULT_HI),
        .RESULT_LO  (RESULT_LO),
        .DIV_BY_ZERO(DIV_BY_ZERO)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues one operation in the current cycle and follows it to DONE.
    task automatic run_op(input logic mb, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag, input bit scramble);
        logic [2*W-1:0] p;
        logic [W-1:0]   eh;
        logic [W-1:0]   el;
        logic           ed;
        int             elat;
        int             ebusy;
        int             lat;
        int             bc;
        if (!mb) begin
            p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            eh = p[2*W-1:W];
            el = p[W-1:0];
            ed = 1'b0;
            elat = W + 1;
            ebusy = W;
        end else if (b == 0) begin
            eh = a;
            el = '1;
            ed = 1'b1;
            elat = 1;
            ebusy = 0;
        end else begin
            eh = a % b;
            el = a / b;
            ed = 1'b0;
            elat = W + 1;
            ebusy = W;
        end
        START = 1'b1; MUL_BAR = mb; A = a; B = b;
        tick();
        START = 1'b0;
        lat = 1;
        bc  = 0;
        while (DONE !== 1'b1 && lat < 40) begin
            if (BUSY === 1'b1) bc++;
            if (scramble) begin
                A = W'($urandom); B = W'($urandom); MUL_BAR = 1'($urandom);
            end
            tick();
            lat++;
        end
        chk({tag, "_lat"},  32'(lat), 32'(elat));
        chk({tag, "_busy"}, 32'(bc), 32'(ebusy));
        chk({tag, "_hi"},   32'(RESULT_HI), 32'(eh));
        chk({tag, "_lo"},   32'(RESULT_LO), 32'(el));
        chk({tag, "_dbz"},  32'(DIV_BY_ZERO), 32'(ed));
        chk({tag, "_busy_at_done"}, 32'(BUSY), 32'(0));
    endtask

    initial begin
        int dcount;
        int lat;
        logic          mb;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;

        RST = 1'b1; START = 1'b0; MUL_BAR = 1'b0; A = '0; B = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(BUSY), 32'(0));
        chk("rst_done", 32'(DONE), 32'(0));
        chk("rst_hi",   32'(RESULT_HI), 32'(0));
        chk("rst_lo",   32'(RESULT_LO), 32'(0));
        chk("rst_dbz",  32'(DIV_BY_ZERO), 32'(0));
        RST = 1'b0;
        tick();

        run_op(1'b0, 8'd13, 8'd11, "mul_13x11", 1'b1);
        tick();
        chk("mul_done_drop", 32'(DONE), 32'(0));
        repeat (3) tick();
        chk("hold_hi", 32'(RESULT_HI), 32'h00);
        chk("hold_lo", 32'(RESULT_LO), 32'h8F);

        run_op(1'b0, 8'hFF, 8'hFF, "mul_ffxff", 1'b0);
        run_op(1'b0, 8'h00, 8'hFF, "mul_0xff", 1'b0);
        run_op(1'b1, 8'd200, 8'd7, "div_200_7", 1'b1);
        run_op(1'b1, 8'd3, 8'd9, "div_3_9", 1'b0);
        tick();
        run_op(1'b1, 8'd5, 8'd0, "div_by_zero", 1'b0);
        run_op(1'b1, 8'd100, 8'd10, "dbz_clear", 1'b0);
        tick();

        // START pulsed mid-run (before iteration 3) must be ignored
        START = 1'b1; MUL_BAR = 1'b0; A = 8'd13; B = 8'd11;
        tick();
        START = 1'b0;
        lat = 1;
        repeat (2) begin tick(); lat++; end
        START = 1'b1; MUL_BAR = 1'b1; A = 8'd5; B = 8'd0;
        tick();
        lat++;
        START = 1'b0;
        chk("ign_busy", 32'(BUSY), 32'(1));
        while (DONE !== 1'b1 && lat < 40) begin tick(); lat++; end
        chk("ign_lat", 32'(lat), 32'(W + 1));
        chk("ign_hi",  32'(RESULT_HI), 32'h00);
        chk("ign_lo",  32'(RESULT_LO), 32'h8F);
        chk("ign_dbz", 32'(DIV_BY_ZERO), 32'(0));
        dcount = 0;
        repeat (10) begin tick(); if (DONE === 1'b1) dcount++; end
        chk("ign_single_done", 32'(dcount), 32'(0));

        // reset asserted before iteration 4 aborts the divide
        START = 1'b1; MUL_BAR = 1'b1; A = 8'd200; B = 8'd7;
        tick();
        START = 1'b0;
        repeat (3) tick();
        RST = 1'b1;
        tick();
        chk("abort_busy", 32'(BUSY), 32'(0));
        chk("abort_done", 32'(DONE), 32'(0));
        chk("abort_hi",   32'(RESULT_HI), 32'(0));
        chk("abort_lo",   32'(RESULT_LO), 32'(0));
        chk("abort_dbz",  32'(DIV_BY_ZERO), 32'(0));
        RST = 1'b0;
        dcount = 0;
        repeat (12) begin tick(); if (DONE === 1'b1) dcount++; end
        chk("abort_no_done", 32'(dcount), 32'(0));
        run_op(1'b0, 8'd9, 8'd9, "mul_9x9", 1'b0);

        // reset and START on the same edge: START dropped
        RST = 1'b1; START = 1'b1; MUL_BAR = 1'b0; A = 8'd3; B = 8'd3;
        tick();
        RST = 1'b0; START = 1'b0;
        chk("rst_start_hi", 32'(RESULT_HI), 32'(0));
        dcount = 0;
        repeat (12) begin tick(); if (DONE === 1'b1 || BUSY === 1'b1) dcount++; end
        chk("rst_start_idle", 32'(dcount), 32'(0));

        // back-to-back: new START in the DONE cycle
        run_op(1'b0, 8'd200, 8'd3, "b2b_a", 1'b0);
        run_op(1'b1, 8'd255, 8'd16, "b2b_b", 1'b0);
        run_op(1'b1, 8'd77, 8'd0, "b2b_c", 1'b0);
        run_op(1'b1, 8'd77, 8'd0, "b2b_d", 1'b0);
        run_op(1'b0, 8'd128, 8'd2, "b2b_e", 1'b0);

        for (int i = 0; i < 40; i++) begin
            mb = 1'($urandom);
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op(mb, ra, rb, "rand", 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_div_seq.md
# mul_div_seq

Parametrised sequential unsigned multiply/divide unit that generalises the combinational array cell (controlled add/subtract with `MUL_BAR` mode select) into a bit-serial datapath. It processes one multiplier or quotient bit per clock, so the area of a full `WIDTH`×`WIDTH` array is traded for `WIDTH` cycles of latency. It sits beside the array multiplier/divider as the low-area option and uses the same mode convention: `MUL_BAR=0` multiplies, `MUL_BAR=1` divides.

## Interface
- `WIDTH`, default 8, operand width in bits; legal range is ≥2.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: synchronous reset, active-high.
- `START` in 1: operation request; sampled only in IDLE or DONE state.
- `MUL_BAR` in 1: 0 selects multiply, 1 selects divide; latched when `START` is accepted.
- `A` in `WIDTH`: multiplicand, or dividend in divide mode; latched when `START` is accepted.
- `B` in `WIDTH`: multiplier, or divisor in divide mode; latched when `START` is accepted.
- `BUSY` out 1: high while in RUN state.
- `DONE` out 1: one-cycle pulse; results are valid from this cycle onward.
- `RESULT_HI` out `WIDTH`: product upper half, or remainder in divide mode.
- `RESULT_LO` out `WIDTH`: product lower half, or quotient in divide mode.
- `DIV_BY_ZERO` out 1: set with `DONE` when a divide had `B=0`; cleared on the next accepted `START`.

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE or DONE, with `START=1`:
  - Latch `A`, `B` and `MUL_BAR`, and clear the iteration counter.
  - Normal case: go to RUN.
  - Divide with `B=0`: go directly to DONE with `RESULT_LO` = all ones, `RESULT_HI` = `A`, `DIV_BY_ZERO=1`.
- DONE with `START=0`: go to IDLE.
- RUN: perform one iteration per cycle. After iteration `WIDTH` completes, go to DONE.
- `START` is ignored in RUN. Changes to `A`, `B` or `MUL_BAR` during RUN have no effect.
- Multiply uses shift-add.
  - Accumulator is 2·`WIDTH` bits, initialised to {0, `B`}.
  - Each iteration: if LSB=1, add `A` to the upper half using a `WIDTH`+1-bit sum. Then shift the whole accumulator, including the carry, right by 1.
  - Final accumulator gives {`RESULT_HI`, `RESULT_LO`} = `A`·`B` exactly. No overflow is possible.
- Divide uses the restoring algorithm.
  - Partial remainder is `WIDTH`+1 bits, initialised to 0; the quotient register is initialised to `A`.
  - Each iteration: shift {remainder, quotient} left by 1, then compute trial = remainder − `B`.
  - If trial ≥ 0: remainder = trial and quotient LSB = 1. Otherwise restore and set quotient LSB = 0.
  - Result: `RESULT_LO` = ⌊`A`/`B`⌋, `RESULT_HI` = `A` mod `B`.
- `RESULT_HI`, `RESULT_LO` and `DIV_BY_ZERO` are registered. They update only when DONE is entered and hold until the next DONE. Intermediate values never appear on the outputs.

## Timing
- Reset values: `BUSY=0`, `DONE=0`, `RESULT_HI=0`, `RESULT_LO=0`, `DIV_BY_ZERO=0`; state is IDLE and the counter is 0.
- Let edge 0 be the edge that samples `START`.
- Normal operation:
  - `BUSY=1` after edges 0 through `WIDTH`−1.
  - Iterations execute at edges 1 through `WIDTH`.
  - `DONE=1` and results are valid in the cycle after edge `WIDTH`.
  - `DONE` deasserts after edge `WIDTH`+1, unless a new `START` re-enters DONE via the divide-by-zero path.
- Divide by zero: `DONE=1` in the cycle after edge 0. `BUSY` stays 0.
- Back-to-back: `START=1` during the DONE cycle is accepted. `BUSY=1` from the next cycle, giving a sustained throughput of one operation per `WIDTH`+1 cycles.
- `RST` has priority over everything.
  - `RST` asserted mid-RUN returns all outputs to their reset values on the next edge.
  - No `DONE` is produced for an aborted operation.
- `RST` and `START` high on the same edge: reset wins and `START` is dropped.

## Test plan
- Multiply, `WIDTH`=8, A=13, B=11, MUL_BAR=0 → `DONE` 8 cycles after the START edge; HI=0x00, LO=0x8F; `BUSY` high for exactly 8 cycles.
- Multiply, A=0xFF, B=0xFF → HI=0xFE, LO=0x01. Also A=0, B=0xFF → HI=LO=0.
- Divide, A=200, B=7, MUL_BAR=1 → LO=28, HI=4, `DIV_BY_ZERO=0`. Also A=3, B=9 → LO=0, HI=3.
- Divide, A=5, B=0 → `DONE` in the cycle after the START edge; LO=0xFF, HI=0x05, `DIV_BY_ZERO=1`. A following valid op clears the flag.
- Start a multiply of 13×11. At iteration 3, pulse `START` with MUL_BAR=1 and new A/B → ignored; result is still 0x008F with a single `DONE`.
- Start 200/7. Assert `RST` at iteration 4 → next cycle all outputs are 0, no `DONE`. Then START 9×9 → 0x0051.
